// File: rtl/branch_predictor.sv
// Direct-mapped branch history table with target buffer.
// Predicts a next-PC for IF and is trained by EX with resolved outcomes.
module branch_predictor #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic        mispredict_q, mispredict_d;
  logic [31:0] branchCnt_q, branchCnt_d;
  logic [31:0] mispredCnt_q, mispredCnt_d;

  logic [IDX_W-1:0] ifIdx, updIdx;
  logic [TAG_W-1:0] ifTag, updTag;
  logic             ifHit, updHit, mispredCond;
  logic             writeMeta, writeTarget, writeCtr;
  logic [1:0]       ctr_d;
  logic             unusedPcBits;

  assign ifIdx  = pc_if[IDX_W+1:2];
  assign ifTag  = pc_if[31:IDX_W+2];
  assign updIdx = upd_pc[IDX_W+1:2];
  assign updTag = upd_pc[31:IDX_W+2];
  assign unusedPcBits = ^{pc_if[1:0], upd_pc[1:0]};

  // Gating with rst_n keeps the prediction neutral for the whole reset period.
  assign ifHit        = rst_n && valid_q[ifIdx] && (tag_q[ifIdx] == ifTag);
  assign pred_taken   = ifHit && ctr_q[ifIdx][1];
  assign pred_next_pc = pred_taken ? target_q[ifIdx] : pc_if + 32'd4;

  assign updHit      = valid_q[updIdx] && (tag_q[updIdx] == updTag);
  assign mispredCond = (upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target));

  always_comb begin
    ctr_d        = ctr_q[updIdx];
    writeMeta    = 1'b0;
    writeTarget  = 1'b0;
    writeCtr     = 1'b0;
    mispredict_d = upd_valid && mispredCond;
    branchCnt_d  = upd_valid ? branchCnt_q + 32'd1 : branchCnt_q;
    mispredCnt_d = mispredict_d ? mispredCnt_q + 32'd1 : mispredCnt_q;
    if (upd_valid) begin
      if (updHit) begin
        writeCtr = 1'b1;
        if (upd_taken) begin
          writeTarget = 1'b1;
          if (ctr_q[updIdx] != 2'b11) ctr_d = ctr_q[updIdx] + 2'd1;
        end else if (ctr_q[updIdx] != 2'b00) begin
          ctr_d = ctr_q[updIdx] - 2'd1;
        end
      end else if (upd_taken) begin
        // A taken miss evicts whatever occupied this index.
        writeMeta   = 1'b1;
        writeTarget = 1'b1;
        writeCtr    = 1'b1;
        ctr_d       = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      mispredict_q <= 1'b0;
      branchCnt_q  <= 32'd0;
      mispredCnt_q <= 32'd0;
    end else begin
      if (writeMeta) valid_q[updIdx] <= 1'b1;
      if (writeCtr)  ctr_q[updIdx]   <= ctr_d;
      mispredict_q <= mispredict_d;
      branchCnt_q  <= branchCnt_d;
      mispredCnt_q <= mispredCnt_d;
    end
  end

  // Tag and target hold no reset; valid_q masks stale contents.
  always_ff @(posedge clk) begin
    if (rst_n && writeMeta)   tag_q[updIdx]    <= updTag;
    if (rst_n && writeTarget) target_q[updIdx] <= upd_target;
  end

  assign mispredict  = mispredict_q;
  assign branch_cnt  = branchCnt_q;
  assign mispred_cnt = mispredCnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES = 16).
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int assertCount = 0;
  int failCount   = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_if          (pc_if),
    .pred_taken     (pred_taken),
    .pred_next_pc   (pred_next_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict     (mispredict),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One update presented for exactly one rising edge; outputs settle 1 ns later.
  task automatic applyStimulus(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                               input logic predTaken, input logic [31:0] predTarget);
    @(negedge clk);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = target;
    upd_pred_taken  = predTaken;
    upd_pred_target = predTarget;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic checkCounts(input string tag, input logic [31:0] br, input logic [31:0] mp, input logic mpFlag);
    checkOutput({tag, "_branch_cnt"}, branch_cnt, br);
    checkOutput({tag, "_mispred_cnt"}, mispred_cnt, mp);
    checkOutput({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, mpFlag});
  endtask

  task automatic checkPredict(input string tag, input logic [31:0] pc, input logic taken, input logic [31:0] nextPc);
    pc_if = pc;
    #1;
    checkOutput({tag, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, taken});
    checkOutput({tag, "_pred_next_pc"}, pred_next_pc, nextPc);
  endtask

  initial begin
    rst_n           = 1'b0;
    pc_if           = 32'h0000_0100;
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;

    #2;
    checkPredict("in_reset", 32'h100, 1'b0, 32'h104);
    checkCounts("in_reset", 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkPredict("post_reset", 32'h100, 1'b0, 32'h104);

    // Allocation with a same-cycle lookup that must still see the old table.
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h104;
    pc_if = 32'h100;
    #1;
    checkOutput("same_cycle_pred_taken", {31'd0, pred_taken}, 32'd0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    checkPredict("alloc", 32'h100, 1'b1, 32'h80);
    checkCounts("alloc", 32'd1, 32'd1, 1'b1);

    // Four correctly predicted taken updates saturate the counter at 11.
    for (int i = 0; i < 4; i++) applyStimulus(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    checkCounts("sat", 32'd5, 32'd1, 1'b0);
    applyStimulus(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    checkPredict("nt1", 32'h100, 1'b1, 32'h80);
    checkCounts("nt1", 32'd6, 32'd2, 1'b1);
    applyStimulus(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    checkPredict("nt2", 32'h100, 1'b0, 32'h104);
    checkCounts("nt2", 32'd7, 32'd3, 1'b1);

    // Retrain 0x100 to weak taken, then evict it with alias 0x140 (index 0).
    applyStimulus(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    checkPredict("retrain", 32'h100, 1'b1, 32'h80);
    applyStimulus(32'h140, 1'b1, 32'h40, 1'b0, 32'h144);
    checkPredict("evicted", 32'h100, 1'b0, 32'h104);
    checkPredict("alias", 32'h140, 1'b1, 32'h40);
    checkCounts("alias", 32'd9, 32'd5, 1'b1);

    // Not-taken miss on index 0 leaves the 0x140 entry alone.
    applyStimulus(32'h200, 1'b0, 32'h0, 1'b0, 32'h204);
    checkCounts("nt_miss", 32'd10, 32'd5, 1'b0);
    checkPredict("nt_miss_200", 32'h200, 1'b0, 32'h204);
    checkPredict("nt_miss_140", 32'h140, 1'b1, 32'h40);

    // Taken hit with a new target overwrites it and counts as a mispredict.
    applyStimulus(32'h140, 1'b1, 32'h60, 1'b1, 32'h40);
    checkPredict("retarget", 32'h140, 1'b1, 32'h60);
    checkCounts("retarget", 32'd11, 32'd6, 1'b1);

    checkPredict("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Preload the mispredict counter just below wrap.
    @(negedge clk);
    force dut.mispredCnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispredCnt_q;
    #1;
    checkOutput("preload", mispred_cnt, 32'hFFFF_FFFF);
    applyStimulus(32'h300, 1'b0, 32'h0, 1'b1, 32'h0);
    checkCounts("wrap1", 32'd12, 32'd0, 1'b1);
    applyStimulus(32'h300, 1'b0, 32'h0, 1'b1, 32'h0);
    checkCounts("wrap2", 32'd13, 32'd1, 1'b1);

    // Asynchronous reset in mid-cycle, then an update held across a reset edge.
    @(posedge clk);
    #3;
    pc_if = 32'h140;
    rst_n = 1'b0;
    #1;
    checkOutput("async_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("async_pred_next_pc", pred_next_pc, 32'h144);
    checkCounts("async", 32'd0, 32'd0, 1'b0);
    upd_valid = 1'b1; upd_pc = 32'h180; upd_taken = 1'b1; upd_target = 32'h20;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h184;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkPredict("after_reset_140", 32'h140, 1'b0, 32'h144);
    checkPredict("after_reset_180", 32'h180, 1'b0, 32'h184);
    checkCounts("after_reset", 32'd0, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
